// File: rtl/sender_fifo_if.sv
// Byte-push handshake and TX-side status bundle for sender_fifo.
// The core drives through the master modport; sender_fifo implements the slave modport.
interface sender_fifo_if #(
  parameter int LOG_DEPTH = 4
);
  logic [7:0]         in;
  logic               in_valid;
  logic               in_ready;
  logic               out;
  logic               busy;
  logic [LOG_DEPTH:0] count;

  modport master (output in, in_valid, input in_ready, out, busy, count);
  modport slave  (input in, in_valid, output in_ready, out, busy, count);
endinterface

// File: rtl/sender_fifo.sv
// UART 8N1 transmitter fed by a 2**LOG_DEPTH byte FIFO, LSB first, SENDER_PERIOD clocks per bit.
// Defining SENDER_SENT_COUNT_EN adds a 32-bit `sent` port counting completed frames.
module sender_fifo #(
  parameter int SENDER_PERIOD = 1292,
  parameter int LOG_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sender_fifo_if.slave bus
`ifdef SENDER_SENT_COUNT_EN
  ,
  output logic [31:0] sent
`endif
);
  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam int TW    = $clog2(SENDER_PERIOD);

  localparam logic [TW-1:0]        TIMER_RELOAD = TW'(SENDER_PERIOD - 1);
  localparam logic [TW-1:0]        TIMER_ONE    = TW'(1);
  localparam logic [LOG_DEPTH:0]   CNT_FULL     = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0]   CNT_ONE      = (LOG_DEPTH + 1)'(1);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE      = LOG_DEPTH'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]           mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           sr_q, sr_d;
  logic                 out_q, out_d;
  logic                 push, pop;

  assign bus.in_ready = (count_q != CNT_FULL);
  assign push         = bus.in_valid && bus.in_ready;
  assign bus.count    = count_q;
  assign bus.out      = out_q;
  assign bus.busy     = (count_q != '0) || (state_q != IDLE);

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    sr_d      = sr_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          sr_d    = mem_q[rd_ptr_q];
          timer_d = TIMER_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          timer_d   = TIMER_RELOAD;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          sr_d    = {1'b0, sr_q[7:1]};
          timer_d = TIMER_RELOAD;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      STOP: begin
        // Chaining straight into the next start bit keeps back-to-back frames gap-free.
        if (timer_q == '0) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            sr_d    = mem_q[rd_ptr_q];
            timer_d = TIMER_RELOAD;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is decoded from the next state so `out` is a clean flop output.
  always_comb begin
    out_d = 1'b1;
    unique case (state_d)
      START:   out_d = 1'b0;
      DATA:    out_d = sr_d[0];
      default: out_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !push) count_d = count_q - CNT_ONE;
  end

  // NOTE: storage has no reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= 3'd0;
      sr_q      <= 8'h00;
      out_q     <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      sr_q      <= sr_d;
      out_q     <= out_d;
    end
  end

`ifdef SENDER_SENT_COUNT_EN
  logic [31:0] sent_q, sent_d;
  logic        frame_done;

  assign frame_done = (state_q == STOP) && (timer_q == '0);
  assign sent       = sent_q;

  always_comb begin
    sent_d = frame_done ? sent_q + 32'd1 : sent_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sent_q <= 32'd0;
    else        sent_q <= sent_d;
  end
`endif
endmodule
